// File: rtl/disp_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package disp_pkg;

  // Per-slot scan phase: blanking guard, then digit drive.
  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Segment pattern with every segment off (active-low segments, common anode).
  localparam logic [6:0] BLANK_CODE = 7'h7F;

  // Width of a digit index for n digits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot counter: counts 0..TICK_DIV-1 and flags the last guard cycle and the
// last cycle of each slot (plus the cycle before it, for registered pulses).
module scan_tick_gen #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic guard_end_c,
  output logic slot_end_c,
  output logic pre_slot_end_c
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  // Free-running slot counter, wraps at TICK_DIV.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (slot_end_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign guard_end_c    = (cnt == CW'(GUARD_CYCLES - 1));
  assign slot_end_c     = (cnt == CW'(TICK_DIV - 1));
  assign pre_slot_end_c = (cnt == CW'(TICK_DIV - 2));

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits sharing
// one decoder. Each slot blanks for GUARD_CYCLES then drives one anode.
// New display values are committed only at frame boundaries.
// Optional build macro: LZS_EN enables leading-zero suppression.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [3:0]              hex_out,
  output logic                    blank,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    frame_done
);

  localparam int unsigned IW = idx_width(NUM_DIGITS);
  localparam int unsigned NW = NUM_DIGITS;
  localparam int unsigned VW = 4 * NUM_DIGITS;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  scan_state_t   state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [NW-1:0] anode_nxt;
  logic          blank_nxt;
  logic [3:0]    hex_nxt;
  logic          frame_done_nxt;

  logic [VW-1:0] active, active_nxt, pending;
  logic          pending_valid;

  logic guard_end_c, slot_end_c, pre_slot_end_c;
  logic frame_end_c;
  logic lit_c;

  scan_tick_gen #(
    .TICK_DIV     (TICK_DIV),
    .GUARD_CYCLES (GUARD_CYCLES)
  ) u_tick (
    .clk            (clk),
    .rst_n          (rst_n),
    .guard_end_c    (guard_end_c),
    .slot_end_c     (slot_end_c),
    .pre_slot_end_c (pre_slot_end_c)
  );

  assign frame_end_c = slot_end_c && (idx == LAST_IDX);

  // Value shown next frame: a same-cycle load bypasses the pending register.
  always_comb begin
    active_nxt = active;
    if (frame_end_c) begin
      if (load) begin
        active_nxt = value;
      end else if (pending_valid) begin
        active_nxt = pending;
      end
    end
  end

`ifdef LZS_EN
  logic [NW-1:0] elig;

  // Digit is eligible if it or any higher nibble of the committed value is nonzero.
  always_comb begin
    elig    = '0;
    elig[0] = 1'b1;
    for (int i = 1; i < int'(NUM_DIGITS); i++) begin
      elig[i] = |(active >> (4 * i));
    end
  end

  assign lit_c = digit_en[idx] & elig[idx];
`else
  assign lit_c = digit_en[idx];
`endif

  // Next-state and next-output logic for the guard/drive scan.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    anode_nxt      = anode_n;
    blank_nxt      = blank;
    hex_nxt        = hex_out;
    frame_done_nxt = pre_slot_end_c && (idx == LAST_IDX);
    case (state)
      GUARD: begin
        if (guard_end_c) begin
          state_nxt = DRIVE;
          if (lit_c) begin
            anode_nxt = ~(NW'(1) << idx);
            blank_nxt = 1'b0;
          end
        end
      end
      DRIVE: begin
        if (slot_end_c) begin
          state_nxt = GUARD;
          idx_nxt   = (idx == LAST_IDX) ? '0 : idx + IW'(1);
          anode_nxt = '1;
          blank_nxt = 1'b1;
          hex_nxt   = 4'(active_nxt >> (32'(idx_nxt) << 2));
        end
      end
      default: state_nxt = GUARD;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= GUARD;
      idx        <= '0;
      anode_n    <= '1;
      blank      <= 1'b1;
      hex_out    <= 4'h0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      anode_n    <= anode_nxt;
      blank      <= blank_nxt;
      hex_out    <= hex_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  // Pending capture and frame-boundary commit of the display value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
    end else begin
      active <= active_nxt;
      if (load) begin
        pending <= value;
      end
      if (frame_end_c) begin
        pending_valid <= 1'b0;
      end else if (load) begin
        pending_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl (NUM_DIGITS=4, TICK_DIV=8, GUARD_CYCLES=2).
module tb_disp_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  digit_en = 4'b1111;
  logic [3:0]  hex_out;
  logic        blank;
  logic [3:0]  anode_n;
  logic        frame_done;

  typedef struct {
    logic [3:0] hex;
    logic [3:0] anode;
    logic       blank;
  } rec_t;

  rec_t q[$];
  rec_t cur;
  int   errors = 0;
  int   checks = 0;
  int   c = 0;
  bit   run = 1'b0;

  disp_scan_ctrl #(
    .NUM_DIGITS   (4),
    .TICK_DIV     (8),
    .GUARD_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .digit_en   (digit_en),
    .hex_out    (hex_out),
    .blank      (blank),
    .anode_n    (anode_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s c=%0d got=%h exp=%h", name, c, act, exp);
    end
  endtask

  // Push the four slot records of one frame: shown value and hand-derived lit mask.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] lit);
    rec_t r;
    logic [15:0] t;
    t = v;
    for (int d = 0; d < 4; d++) begin
      r.hex   = t[3:0];
      r.anode = lit[d] ? 4'(~(4'b0001 << d)) : 4'b1111;
      r.blank = ~lit[d];
      q.push_back(r);
      t = t >> 4;
    end
  endtask

  // Monitor: one record per slot, compared on every cycle of that slot.
  always @(negedge clk) begin
    if (!run) begin
      c = 0;
    end else begin
      if (c % 8 == 0) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL underflow c=%0d got=empty exp=record", c);
        end else begin
          cur = q.pop_front();
        end
      end
      chk("hex_out", hex_out, cur.hex);
      if (c % 8 < 2) begin
        chk("guard_anode", anode_n, 4'b1111);
        chk("guard_blank", {3'b0, blank}, 4'd1);
      end else begin
        chk("drive_anode", anode_n, cur.anode);
        chk("drive_blank", {3'b0, blank}, {3'b0, cur.blank});
      end
      chk("frame_done", {3'b0, frame_done}, {3'b0, (c % 32 == 31)});
      c++;
    end
  end

  initial begin
    rec_t r0;
    r0.hex = 4'h0; r0.anode = 4'b1110; r0.blank = 1'b0;
    q.push_back(r0);
    push_frame(16'h0000, 4'b1111);
    push_frame(16'h12AF, 4'b1111);
    push_frame(16'h12AF, 4'b1011);
    push_frame(16'h5678, 4'b1111);
`ifdef LZS_EN
    push_frame(16'h00C3, 4'b0011);
    push_frame(16'h0050, 4'b0011);
    push_frame(16'h0000, 4'b0001);
`else
    push_frame(16'h00C3, 4'b1111);
    push_frame(16'h0050, 4'b1111);
    push_frame(16'h0000, 4'b1111);
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_anode", anode_n, 4'b1111);
    chk("rst_blank", {3'b0, blank}, 4'd1);
    chk("rst_hex", hex_out, 4'h0);
    chk("rst_frame_done", {3'b0, frame_done}, 4'd0);

    // Release, run into digit 0 drive, then reset mid-drive.
    @(posedge clk);
    #1 rst_n = 1'b1; run = 1'b1;
    repeat (6) @(negedge clk);
    #1 rst_n = 1'b0; run = 1'b0;
    #1;
    chk("mid_rst_anode", anode_n, 4'b1111);
    chk("mid_rst_blank", {3'b0, blank}, 4'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; run = 1'b1;

    // Directed input schedule, applied mid-cycle for sampling at the next edge.
    for (int cyc = 0; cyc < 224; cyc++) begin
      @(negedge clk);
      #1;
      load = 1'b0;
      case (cyc)
        5:   begin load = 1'b1; value = 16'h12AF; end
        60:  digit_en = 4'b1011;
        70:  begin load = 1'b1; value = 16'h1234; end
        80:  begin load = 1'b1; value = 16'h5678; end
        92:  digit_en = 4'b1111;
        127: begin load = 1'b1; value = 16'h00C3; end
        140: begin load = 1'b1; value = 16'h0050; end
        170: begin load = 1'b1; value = 16'h0000; end
        default: ;
      endcase
    end
    run = 1'b0;
    chk("queue_left", 4'(q.size()), 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
